// File: rtl/nonce_uart_tx.sv
// nonce_uart_tx: queues found nonces in a small FIFO and returns each one to the host as 8N1 UART bytes.
// Defining NONCE_TX_CHECKSUM_EN appends an XOR checksum byte to every frame (6 bytes instead of 5).
module nonce_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        nonce_valid,
   input  logic [31:0]                 nonce,
   output logic                        nonce_ready,
   output logic                        tx,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   // state | meaning
   // IDLE  | line idle, waiting for a queued nonce
   // LOAD  | one cycle: pop FIFO head into the frame register, line high
   // START | start bit (low)
   // DATA  | eight data bits, LSB first
   // STOP  | stop bit (high), then next byte, next nonce or idle
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef NONCE_TX_CHECKSUM_EN
   localparam logic [2:0] LAST_BYTE = 3'd5;
`else
   localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [2:0]         byte_q, byte_d;
   logic [31:0]        word_q, word_d;
   logic               tx_q, tx_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W:0]     level_q, level_d;
   logic [PTR_W-1:0]   wr_q, wr_d;
   logic [PTR_W-1:0]   rd_q, rd_d;
   logic [31:0]        mem [FIFO_DEPTH];
   logic               push, pop, bit_end;
   logic [7:0]         cur_byte;

   function automatic logic [7:0] frame_byte(input logic [31:0] n, input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h55;
      case (idx)
         3'd1:    b = n[31:24];
         3'd2:    b = n[23:16];
         3'd3:    b = n[15:8];
         3'd4:    b = n[7:0];
`ifdef NONCE_TX_CHECKSUM_EN
         3'd5:    b = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
`endif
         default: b = 8'h55;
      endcase
      return b;
   endfunction

   // Ready comes from the registered level, so a pop never frees a slot in its own cycle.
   assign nonce_ready = (level_q != FULL);
   assign push        = nonce_valid && nonce_ready;
   assign tx          = tx_q;
   assign busy        = (state_q != IDLE);
   assign overflow    = ovf_q;
   assign level       = level_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      word_d  = word_q;
      pop     = 1'b0;
      bit_end = (cnt_q == CNT_MAX);
      case (state_q)
         IDLE: begin
            if (level_q != '0) state_d = LOAD;
         end
         LOAD: begin
            pop     = 1'b1;
            word_d  = mem[rd_q];
            byte_d  = 3'd0;
            bit_d   = 3'd0;
            cnt_d   = '0;
            state_d = START;
         end
         START: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               if (byte_q == LAST_BYTE) begin
                  state_d = (level_q != '0) ? LOAD : IDLE;
               end else begin
                  byte_d  = byte_q + 3'd1;
                  state_d = START;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The line is registered from the next state so it changes only on clock edges.
      cur_byte = frame_byte(word_d, byte_d);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop  ? rd_q + 1'b1 : rd_q;
      ovf_d   = ovf_q | (nonce_valid & ~nonce_ready);
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         byte_q  <= 3'd0;
         word_q  <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         level_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         level_q <= level_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= nonce;
   end

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Testbench for nonce_uart_tx: line-level reference model plus UART decoder and scoreboard.
// Works with NONCE_TX_CHECKSUM_EN either defined or not.
module tb_nonce_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef NONCE_TX_CHECKSUM_EN
   localparam int NBYTES   = 6;
   localparam int BUSY_ONE = 241;
`else
   localparam int NBYTES   = 5;
   localparam int BUSY_ONE = 201;
`endif
   localparam int FRAME_CYC = 10 * NBYTES * CPB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nonce_valid;
   logic [31:0] nonce;
   logic        nonce_ready;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [2:0]  level;

   nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .nonce_valid(nonce_valid), .nonce(nonce),
      .nonce_ready(nonce_ready), .tx(tx), .busy(busy), .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   function automatic logic [7:0] fbyte(input logic [31:0] n, input int i);
      logic [7:0] b;
      case (i)
         0:       b = 8'h55;
         1:       b = n[31:24];
         2:       b = n[23:16];
         3:       b = n[15:8];
         4:       b = n[7:0];
         default: b = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
      endcase
      return b;
   endfunction

   // Serial line value of bit j of a whole frame: start, 8 data LSB first, stop per byte.
   function automatic logic fbit(input logic [31:0] n, input int j);
      int pos;
      logic [7:0] b;
      pos = j % 10;
      b   = fbyte(n, j / 10);
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos-1];
   endfunction

   // Reference model: queue of nonces, line is idle, in a one-cycle load, or k cycles into a frame.
   typedef enum int {M_IDLE, M_LOAD, M_FRAME} mmode_t;
   mmode_t      m_mode = M_IDLE;
   logic [31:0] mq[$];
   logic [31:0] m_cur = '0;
   int          m_k = 0;
   bit          m_ovf = 1'b0;
   logic [7:0]  exp_bytes[$];

   always @(posedge clk) begin
      int  pre;
      bit  psh;
      cyc++;
      if (!rst_n) begin
         mq.delete();
         exp_bytes.delete();
         m_mode = M_IDLE;
         m_k    = 0;
         m_ovf  = 1'b0;
      end else begin
         pre = mq.size();
         psh = nonce_valid && (pre < DEPTH);
         if (nonce_valid && pre >= DEPTH) m_ovf = 1'b1;
         case (m_mode)
            M_IDLE: if (pre != 0) m_mode = M_LOAD;
            M_LOAD: begin
               m_cur  = mq.pop_front();
               m_k    = 0;
               m_mode = M_FRAME;
            end
            default: begin
               m_k++;
               if (m_k == FRAME_CYC) m_mode = (pre != 0) ? M_LOAD : M_IDLE;
            end
         endcase
         if (psh) begin
            mq.push_back(nonce);
            for (int b = 0; b < NBYTES; b++) exp_bytes.push_back(fbyte(nonce, b));
         end
      end
   end

   // UART receiver on the DUT line, sampling mid-bit on falling clock edges.
   logic [7:0] rx_q[$];
   bit         rx_on = 1'b0;
   int         rx_n = 0;
   logic [7:0] rx_sh = '0;

   always @(negedge clk) begin
      int bi;
      if (!rst_n) begin
         rx_q.delete();
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on = 1'b1;
            rx_n  = 0;
         end
      end else begin
         rx_n++;
         if (rx_n % CPB == CPB / 2) begin
            bi = rx_n / CPB;
            if (bi >= 1 && bi <= 8) rx_sh[bi-1] = tx;
            if (bi == 9) begin
               rx_q.push_back(rx_sh);
               rx_on = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n;
      n = 0;
      while ((busy || level != 3'd0) && n < limit) begin
         tick();
         n++;
      end
      check(name, (n < limit) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_frames(input string name, input int base, input logic [31:0] ns [8], input int cnt);
      int idx;
      logic [7:0] got;
      check({name, "_len"}, rx_q.size() - base, cnt * NBYTES);
      for (int f = 0; f < cnt; f++) begin
         for (int b = 0; b < NBYTES; b++) begin
            idx = base + f * NBYTES + b;
            got = (idx < rx_q.size()) ? rx_q[idx] : 8'h00;
            check(name, got, fbyte(ns[f], b));
         end
      end
   endtask

   initial begin
      int          e, t0, t1, base, n;
      logic [7:0]  lit[6];
      logic [31:0] ns[8];
      int          p;

      rst_n = 1'b0;
      nonce_valid = 1'b0;
      nonce = '0;
      repeat (2) tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_level", level, 0);
      check("rst_ready", nonce_ready, 1);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               check("cyc_tx", tx, (m_mode == M_FRAME) ? fbit(m_cur, m_k / CPB) : 1'b1);
               check("cyc_busy", busy, (m_mode != M_IDLE) ? 1 : 0);
               check("cyc_level", level, mq.size());
               check("cyc_ready", nonce_ready, (mq.size() < DEPTH) ? 1 : 0);
               check("cyc_ovf", overflow, m_ovf);
            end
         end
      join_none

      // Single nonce: latency, busy length, literal byte stream.
      tick();
      base = rx_q.size();
      nonce_valid = 1'b1;
      nonce = 32'hDEADBEEF;
      e = cyc + 1;
      tick();
      nonce_valid = 1'b0;
      check("lat_level", level, 1);
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      t0 = cyc;
      check("lat_start", t0 - e, 2);
      n = 0;
      while (busy && n < FRAME_CYC + 50) begin
         tick();
         n++;
      end
      t1 = cyc;
      check("busy_len", t1 - (e + 1), BUSY_ONE);
      check("idle_tx", tx, 1);
      lit = '{8'h55, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      check("single_len", rx_q.size() - base, NBYTES);
      for (int b = 0; b < NBYTES; b++)
         check("single_byte", (base + b < rx_q.size()) ? rx_q[base+b] : 8'h00, lit[b]);

      // Overflow: nonces 1..6 on consecutive edges from idle.
      base = rx_q.size();
      e = cyc + 1;
      for (int i = 1; i <= 6; i++) begin
         nonce_valid = 1'b1;
         nonce = 32'(i);
         tick();
      end
      nonce_valid = 1'b0;
      check("ovf_level", level, 4);
      check("ovf_flag", overflow, 1);
      check("ovf_ready", nonce_ready, 0);
      n = 0;
      while (busy && n < 6 * FRAME_CYC) begin
         tick();
         n++;
      end
      check("ovf_busy_len", cyc - (e + 1), 5 * FRAME_CYC + 5);
      for (int i = 0; i < 8; i++) ns[i] = 32'(i + 1);
      check_frames("ovf_bytes", base, ns, 5);

      // Simultaneous push and pop at level 2 in mid-stream.
      base = rx_q.size();
      ns[0] = 32'hA5A50001; ns[1] = 32'h0B0B0B0B; ns[2] = 32'hC0FFEE33; ns[3] = 32'h13579BDF;
      for (int i = 0; i < 3; i++) begin
         nonce_valid = 1'b1;
         nonce = ns[i];
         tick();
      end
      nonce_valid = 1'b0;
      n = 0;
      while (m_mode != M_LOAD && n < FRAME_CYC + 20) begin
         tick();
         n++;
      end
      check("sim_pre_level", level, 2);
      nonce_valid = 1'b1;
      nonce = ns[3];
      tick();
      nonce_valid = 1'b0;
      check("sim_level", level, 2);
      wait_drain("sim_drain", 5 * FRAME_CYC);
      check_frames("sim_bytes", base, ns, 4);

      // Reset during byte 2 of a frame with a second nonce queued.
      base = rx_q.size();
      nonce_valid = 1'b1;
      nonce = 32'h12345678;
      tick();
      nonce = 32'h9ABCDEF0;
      tick();
      nonce_valid = 1'b0;
      n = 0;
      while (rx_q.size() < base + 2 && n < FRAME_CYC) begin
         tick();
         n++;
      end
      repeat (3 * CPB) tick();
      check("pre_rst_ovf", overflow, 1);
      check("pre_rst_level", level, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_level", level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf", overflow, 0);
      base = rx_q.size();
      nonce_valid = 1'b1;
      nonce = 32'h00000001;
      tick();
      nonce_valid = 1'b0;
      wait_drain("rst_drain", 2 * FRAME_CYC);
      lit = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      check("post_rst_len", rx_q.size() - base, NBYTES);
      for (int b = 0; b < NBYTES; b++)
         check("post_rst_byte", (base + b < rx_q.size()) ? rx_q[base+b] : 8'h00, lit[b]);

      // Randomized traffic: bursts that overflow the FIFO alternate with sparse offers.
      for (int seg = 0; seg < 6; seg++) begin
         p = (seg % 2 == 0) ? 30 : 1;
         for (int c = 0; c < 300; c++) begin
            nonce_valid = ($urandom_range(0, 99) < p);
            nonce = $urandom;
            tick();
         end
      end
      nonce_valid = 1'b0;
      wait_drain("rand_drain", 8 * FRAME_CYC);
      check("sb_len", rx_q.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size(); i++)
         check("sb_byte", (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_bytes[i]);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nonce_uart_tx.md
# nonce_uart_tx

Result-return transmitter for the miner. Accepts each winning 32-bit nonce from the hashing core through a valid/ready handshake and buffers it in a small FIFO. Each nonce is serialised as a framed 8N1 UART byte stream back to the host, which is the opposite direction to the header/target work path. The block sits between the miner core's nonce output and the board TX pin, and runs on the same `clk` as the core.

## Interface
- `CLKS_PER_BIT`, 434: `clk` cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4: nonce buffer entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `nonce_valid`  in  1  core presents a found nonce.
- `nonce`  in  32  found nonce value.
- `nonce_ready`  out  1  FIFO not full; decoded from the registered level.
- `tx`  out  1  UART serial line; idle high.
- `busy`  out  1  a frame is in progress (any state other than IDLE).
- `overflow`  out  1  sticky: a nonce was offered while the FIFO was full.
- `level`  out  log2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- Push: on an edge where `nonce_valid && nonce_ready`, `nonce` is written to the FIFO.
- `nonce_valid` while `!nonce_ready`: the nonce is dropped and `overflow` is set. `overflow` is cleared only by reset.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE→LOAD when `level != 0`.
  - LOAD (1 cycle): pop the FIFO head into the frame shift register, set byte index to 0, drive `tx` = 1, then go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. Next state is START for the next byte. After the last byte, next state is LOAD if `level != 0`, else IDLE.
- Frame byte order: 0x55 sync, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0], then the optional checksum (see Configuration).
- Checksum = XOR of the four nonce bytes.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 at CLKS_PER_BIT-1.
- Push and pop on the same edge: `level` is unchanged and the data ordering is preserved.
- When full, a pop does not free a slot in that same cycle. `nonce_ready` is still low, so a simultaneous offer is dropped and `overflow` is set.

## Timing
- Reset values (on the first edge with `rst_n`=0):
  - `tx`=1, `busy`=0, `overflow`=0, `level`=0, `nonce_ready`=1.
  - FSM goes to IDLE and the FIFO pointers are cleared.
- Reset mid-frame: the frame is abandoned, `tx` is high from the next edge, and queued nonces are discarded.
- Latency: for a nonce accepted at edge E into an empty FIFO while IDLE:
  - `level`=1 after E;
  - LOAD after E+1, and the pop takes effect at E+2;
  - `tx` goes low (start bit) from edge E+2.
- Frame length: 10·N·CLKS_PER_BIT cycles, where N = 6 bytes, or 5 without the checksum.
- Back-to-back frames: exactly one LOAD cycle (`tx` high) between the last stop bit and the next start bit.
- `busy` deasserts on the edge that enters IDLE.

## Configuration
- `NONCE_TX_CHECKSUM_EN` defined: the 6-byte frame is sent, with the checksum byte last.
- `NONCE_TX_CHECKSUM_EN` not defined: the 5-byte frame is sent. No checksum logic is synthesised, and the byte-index terminal count is 4.

## Test plan
- Single nonce, CLKS_PER_BIT=4, checksum on, offer 0xDEADBEEF at edge E:
  - `tx` low from E+2;
  - decoded bytes 0x55, 0xDE, 0xAD, 0xBE, 0xEF, 0x22;
  - `busy` high for 240+1 cycles, then IDLE with `tx`=1.
- Same stimulus with the macro undefined: bytes 0x55, 0xDE, 0xAD, 0xBE, 0xEF only; the frame lasts 200 cycles.
- Overflow, FIFO_DEPTH=4, nonces 1..6 offered on 6 consecutive edges from idle:
  - nonce 1 transmitted; 2, 3, 4, 5 queued (`level`=4);
  - 6 dropped, `overflow`=1, `nonce_ready`=0;
  - all five frames then emerge in order 1–5, each separated by exactly one high LOAD cycle.
- Simultaneous push/pop: with `level`=2 mid-frame, offer a nonce on the edge the FSM pops.
  - `level` stays 2 and no nonce is lost or reordered.
- Reset mid-DATA: assert `rst_n`=0 for one edge during byte 2.
  - Next cycle: `tx`=1, `level`=0, `busy`=0, `overflow`=0.
  - A subsequent nonce 0x00000001 yields the frame 0x55 00 00 00 01 01.
- Bit timing, CLKS_PER_BIT=434: every `tx` transition is spaced by a multiple of 434 cycles within a frame, with no glitch on `tx`.
